// File: rtl/daq_trig_responder.sv
// DAQ-side trigger responder: delayed capture window into a sample buffer,
// hold-for-readout handshake, and missed-trigger bookkeeping.
module daq_trig_responder #(
  parameter int ADDR_W = 10,
  parameter int DLY_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              trig_in,
  input  logic [5:0]        pulse_ctr,
  input  logic [DLY_W-1:0]  cap_dly,
  input  logic [ADDR_W-1:0] cap_len,
  input  logic              readout_done,
  output logic              trig_rdy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              data_rdy,
  output logic [5:0]        trig_tag,
  output logic [7:0]        missed_ctr,
  output logic              overrun
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DELAY   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] ARM     = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              run_s1_q, run_s1_d, run_s2_q, run_s2_d;
  logic              rd_s1_q, rd_s1_d, rd_s2_q, rd_s2_d, rd_prev_q, rd_prev_d;
  logic              trig_rdy_q, trig_rdy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              data_rdy_q, data_rdy_d;
  logic [5:0]        trig_tag_q, trig_tag_d;
  logic [7:0]        missed_q, missed_d;
  logic              overrun_q, overrun_d;
  logic [DLY_W-1:0]  dly_ctr_q, dly_ctr_d;
  logic [ADDR_W-1:0] len_q, len_d;

  logic              rd_rise;
  logic              missed_trig;
  logic [ADDR_W-1:0] last_addr;

  assign rd_rise     = rd_s2_q & ~rd_prev_q;
  assign missed_trig = trig_in & run_s2_q & (state_q != IDLE);
  // len_q of 0 wraps to all-ones, giving the full 2^ADDR_W sample window
  assign last_addr   = len_q - 1'b1;

  always_comb begin
    run_s1_d   = run;
    run_s2_d   = run_s1_q;
    rd_s1_d    = readout_done;
    rd_s2_d    = rd_s1_q;
    rd_prev_d  = rd_s2_q;
    state_d    = state_q;
    trig_rdy_d = trig_rdy_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    data_rdy_d = data_rdy_q;
    trig_tag_d = trig_tag_q;
    missed_d   = missed_q;
    overrun_d  = overrun_q;
    dly_ctr_d  = dly_ctr_q;
    len_d      = len_q;

    if (!run_s2_q) begin
      state_d    = IDLE;
      trig_rdy_d = 1'b1;
      wr_en_d    = 1'b0;
      wr_addr_d  = '0;
      data_rdy_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_in) begin
            trig_rdy_d = 1'b0;
            trig_tag_d = pulse_ctr;
            dly_ctr_d  = cap_dly;
            len_d      = cap_len;
            state_d    = DELAY;
          end
        end
        DELAY: begin
          if (dly_ctr_q == '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            state_d   = CAPTURE;
          end else begin
            dly_ctr_d = dly_ctr_q - 1'b1;
          end
        end
        CAPTURE: begin
          if (wr_addr_q == last_addr) begin
            wr_en_d    = 1'b0;
            wr_addr_d  = '0;
            data_rdy_d = 1'b1;
            state_d    = HOLD;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
        HOLD: begin
          if (rd_rise) begin
            data_rdy_d = 1'b0;
            overrun_d  = 1'b0;
            state_d    = ARM;
          end
        end
        ARM: begin
          trig_rdy_d = 1'b1;
          state_d    = IDLE;
        end
        default: begin
          state_d    = IDLE;
          trig_rdy_d = 1'b1;
          wr_en_d    = 1'b0;
          wr_addr_d  = '0;
          data_rdy_d = 1'b0;
        end
      endcase
    end

    // a rejected trigger overrides a same-cycle readout clear of overrun
    if (missed_trig) begin
      overrun_d = 1'b1;
      if (missed_q != 8'hFF) missed_d = missed_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      run_s1_q   <= 1'b0;
      run_s2_q   <= 1'b0;
      rd_s1_q    <= 1'b0;
      rd_s2_q    <= 1'b0;
      rd_prev_q  <= 1'b0;
      trig_rdy_q <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      data_rdy_q <= 1'b0;
      trig_tag_q <= '0;
      missed_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_s1_q   <= run_s1_d;
      run_s2_q   <= run_s2_d;
      rd_s1_q    <= rd_s1_d;
      rd_s2_q    <= rd_s2_d;
      rd_prev_q  <= rd_prev_d;
      trig_rdy_q <= trig_rdy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      data_rdy_q <= data_rdy_d;
      trig_tag_q <= trig_tag_d;
      missed_q   <= missed_d;
      overrun_q  <= overrun_d;
    end
  end

  // Delay and length registers are always loaded before use, so they need no reset
  always_ff @(posedge clk) begin
    dly_ctr_q <= dly_ctr_d;
    len_q     <= len_d;
  end

  assign trig_rdy   = trig_rdy_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign data_rdy   = data_rdy_q;
  assign trig_tag   = trig_tag_q;
  assign missed_ctr = missed_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_daq_trig_responder.sv
// Self-checking bench for daq_trig_responder: directed vector table, hand-written
// corner sequences and randomized traffic against a timestamp-based reference model.
module tb_daq_trig_responder;
  localparam int ADDR_W = 10;
  localparam int DLY_W  = 8;

  logic              clk = 1'b0;
  logic              rst, run, trig_in, readout_done;
  logic [5:0]        pulse_ctr;
  logic [DLY_W-1:0]  cap_dly;
  logic [ADDR_W-1:0] cap_len;
  logic              trig_rdy, wr_en, data_rdy, overrun;
  logic [ADDR_W-1:0] wr_addr;
  logic [5:0]        trig_tag;
  logic [7:0]        missed_ctr;

  daq_trig_responder #(.ADDR_W(ADDR_W), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst(rst), .run(run), .trig_in(trig_in), .pulse_ctr(pulse_ctr),
    .cap_dly(cap_dly), .cap_len(cap_len), .readout_done(readout_done),
    .trig_rdy(trig_rdy), .wr_en(wr_en), .wr_addr(wr_addr), .data_rdy(data_rdy),
    .trig_tag(trig_tag), .missed_ctr(missed_ctr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 3;
  bit run_h [0:65535];
  bit rd_h  [0:65535];

  // Reference model: one accepted trigger described by its acceptance edge,
  // delay and length; rel is the edge at which readout released the buffer.
  bit m_busy = 0;
  int m_acc = 0, m_dly = 0, m_len = 1, m_rel = -1;
  int m_tag = 0, m_missed = 0;
  bit m_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic void model_edge(int e, bit trig, int pc, int dly, int len);
    bit run_s, rise;
    run_s = run_h[e-2];
    rise  = rd_h[e-2] && !rd_h[e-3];
    if (!run_s) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (trig) begin
        m_busy = 1; m_acc = e; m_dly = dly; m_len = (len == 0) ? 1024 : len;
        m_rel = -1; m_tag = pc;
      end
    end else begin
      if (m_rel >= 0 && e == m_rel + 1) m_busy = 0;
      else if (m_rel < 0 && e >= m_acc + m_dly + m_len + 2 && rise) begin
        m_rel = e; m_ovr = 0;
      end
      if (trig) begin
        m_ovr = 1;
        if (m_missed < 255) m_missed++;
      end
    end
  endfunction

  task automatic check_model();
    int first, exp_addr;
    bit exp_wr, exp_drdy;
    first    = m_acc + m_dly + 1;
    exp_wr   = m_busy && m_rel < 0 && cyc >= first && cyc < first + m_len;
    exp_drdy = m_busy && m_rel < 0 && cyc >= first + m_len;
    exp_addr = exp_wr ? (cyc - first) : 0;
    chk("trig_rdy", 32'(trig_rdy), 32'(!m_busy));
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
    chk("data_rdy", 32'(data_rdy), 32'(exp_drdy));
    chk("trig_tag", 32'(trig_tag), 32'(m_tag));
    chk("missed_ctr", 32'(missed_ctr), 32'(m_missed));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic tick();
    int e, pc, d, l;
    bit t;
    e = cyc + 1;
    run_h[e] = run; rd_h[e] = readout_done;
    t = trig_in; pc = pulse_ctr; d = cap_dly; l = cap_len;
    @(posedge clk);
    cyc = e;
    model_edge(e, t, pc, d, l);
    #1;
    check_model();
  endtask

  task automatic pulse_trig();
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_busy = 0; m_tag = 0; m_missed = 0; m_ovr = 0; m_rel = -1;
    for (int i = cyc - 2; i <= cyc; i++) begin
      run_h[i] = 0; rd_h[i] = 0;
    end
    check_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit trig;
    bit e_rdy;
    bit e_wr;
    int e_addr;
    bit e_drdy;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[7];
    int   nwr, last_a, k;
    bit   seen;

    tv[0] = '{1, 0, 0, 0, 0};
    tv[1] = '{0, 0, 1, 0, 0};
    tv[2] = '{0, 0, 1, 1, 0};
    tv[3] = '{0, 0, 1, 2, 0};
    tv[4] = '{0, 0, 1, 3, 0};
    tv[5] = '{0, 0, 0, 0, 1};
    tv[6] = '{0, 0, 0, 0, 1};

    run = 0; trig_in = 0; readout_done = 0; pulse_ctr = 0; cap_dly = 0; cap_len = 0;
    do_reset();
    run = 1;
    repeat (3) tick();

    // basic capture from the vector table
    cap_dly = 0; cap_len = 4; pulse_ctr = 6'd17;
    for (int i = 0; i < 7; i++) begin
      trig_in = tv[i].trig;
      tick();
      trig_in = 0;
      chk("t1_trig_rdy", 32'(trig_rdy), 32'(tv[i].e_rdy));
      chk("t1_wr_en", 32'(wr_en), 32'(tv[i].e_wr));
      chk("t1_wr_addr", 32'(wr_addr), 32'(tv[i].e_addr));
      chk("t1_data_rdy", 32'(data_rdy), 32'(tv[i].e_drdy));
    end
    chk("t1_trig_tag", 32'(trig_tag), 32'd17);

    // readout handshake: 3 edges to release, 1 more to re-arm
    readout_done = 1;
    tick(); tick();
    chk("t3_hold", 32'(data_rdy), 32'd1);
    tick();
    chk("t3_release", 32'(data_rdy), 32'd0);
    chk("t3_arm", 32'(trig_rdy), 32'd0);
    tick();
    chk("t3_rdy_back", 32'(trig_rdy), 32'd1);

    // abort mid-capture at wr_addr 2
    cap_dly = 0; cap_len = 8; pulse_ctr = 6'd33;
    pulse_trig();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (wr_en === 1'b1 && wr_addr == 2) seen = 1;
    end
    chk("t5_reach_addr2", 32'(seen), 32'd1);
    run = 0;
    repeat (3) tick();
    chk("t5_wr_en", 32'(wr_en), 32'd0);
    chk("t5_wr_addr", 32'(wr_addr), 32'd0);
    chk("t5_data_rdy", 32'(data_rdy), 32'd0);
    chk("t5_trig_rdy", 32'(trig_rdy), 32'd1);
    chk("t5_tag_kept", 32'(trig_tag), 32'd33);
    for (int i = 0; i < 4; i++) begin
      pulse_trig();
      tick();
    end
    chk("t5_no_miss", 32'(missed_ctr), 32'd0);
    chk("t5_no_capture", 32'(trig_rdy), 32'd1);
    run = 1;
    repeat (3) tick();

    // delay 5, full length, with missed triggers in CAPTURE and HOLD
    cap_dly = 5; cap_len = 0; pulse_ctr = 6'd5;
    pulse_trig();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_first_wr", 32'(wr_en), (i == 5) ? 32'd1 : 32'd0);
    end
    nwr = 1; last_a = 0; k = 0;
    while (data_rdy !== 1'b1 && k < 1100) begin
      if (wr_addr == 100 || wr_addr == 200 || wr_addr == 300) pulse_trig();
      else tick();
      if (wr_en === 1'b1) begin nwr++; last_a = wr_addr; end
      k++;
    end
    chk("t2_nwrites", 32'(nwr), 32'd1024);
    chk("t2_last_addr", 32'(last_a), 32'd1023);
    chk("t4_miss3", 32'(missed_ctr), 32'd3);
    for (int i = 0; i < 300; i++) begin
      pulse_trig();
      tick();
    end
    chk("t3_no_second_release", 32'(data_rdy), 32'd1);
    chk("t4_missed_sat", 32'(missed_ctr), 32'd255);
    chk("t4_overrun", 32'(overrun), 32'd1);
    readout_done = 0;
    repeat (3) tick();
    readout_done = 1;
    repeat (3) tick();
    chk("t4_ovr_clear", 32'(overrun), 32'd0);
    chk("t4_drdy_clear", 32'(data_rdy), 32'd0);
    tick();
    chk("t4_rearm", 32'(trig_rdy), 32'd1);
    chk("t4_missed_kept", 32'(missed_ctr), 32'd255);
    readout_done = 0;

    // reset mid-delay, then a normal capture
    cap_dly = 20; cap_len = 3; pulse_ctr = 6'd44;
    pulse_trig();
    repeat (3) tick();
    do_reset();
    chk("t6_missed_rst", 32'(missed_ctr), 32'd0);
    chk("t6_tag_rst", 32'(trig_tag), 32'd0);
    repeat (3) tick();
    cap_dly = 1; cap_len = 2; pulse_ctr = 6'd9;
    pulse_trig();
    repeat (6) tick();
    chk("t6_tag", 32'(trig_tag), 32'd9);
    chk("t6_data_rdy", 32'(data_rdy), 32'd1);

    // randomized traffic against the reference model
    for (int i = 0; i < 4000; i++) begin
      trig_in   = ($urandom_range(0, 9) == 0);
      pulse_ctr = 6'($urandom);
      cap_dly   = DLY_W'($urandom_range(0, 6));
      cap_len   = ($urandom_range(0, 30) == 0) ? '0 : ADDR_W'($urandom_range(1, 12));
      if (run) begin
        if ($urandom_range(0, 299) == 0) run = 0;
      end else if ($urandom_range(0, 9) == 0) run = 1;
      if ($urandom_range(0, 39) == 0) readout_done = ~readout_done;
      tick();
    end
    trig_in = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/daq_trig_responder.md
Name: daq_trig_responder

Overview:
DAQ-side counterpart of the trigger divider. It accepts the divided trigger (trig_in) and runs a delayed capture window that drives sample-buffer write strobes and addresses. It then holds the buffer until the readout side signals completion, and only then re-asserts trig_rdy, which releases the divider's block. It also tags each capture with the divider's pulse count and counts triggers that arrive while it is busy.

Parameters:
ADDR_W, 10, sample-buffer address width; maximum capture length 2^ADDR_W.
DLY_W, 8, width of the pre-capture delay setting.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
run  in  1  async level; 2-FF synchronised; low aborts any capture.
trig_in  in  1  single-cycle trigger pulse, synchronous to clk (trig_out of the divider).
pulse_ctr  in  6  divider pulse counter, synchronous; sampled on accepted trigger.
cap_dly  in  DLY_W  pre-capture delay in cycles; quasi-static; sampled on accepted trigger.
cap_len  in  ADDR_W  samples per capture; 0 means 2^ADDR_W; sampled on accepted trigger.
readout_done  in  1  async level from UART/readout; 2-FF synchronised plus rising-edge detect.
trig_rdy  out  1  high = ready for a new trigger.
wr_en  out  1  buffer write strobe, one sample per cycle.
wr_addr  out  ADDR_W  buffer write address.
data_rdy  out  1  capture complete, buffer held for readout.
trig_tag  out  6  pulse_ctr latched at the accepted trigger.
missed_ctr  out  8  saturating count of triggers rejected while busy.
overrun  out  1  sticky flag, set when a trigger is rejected.

Behaviour:
- Reset values (asynchronous rst):
  - state = IDLE, trig_rdy = 1.
  - wr_en = 0, wr_addr = 0, data_rdy = 0.
  - trig_tag = 0, missed_ctr = 0, overrun = 0.
  - All synchroniser flops = 0.
- All outputs are registered.
- IDLE (trig_rdy = 1). On a clock edge with trig_in = 1 and run_s = 1:
  - trig_rdy <= 0.
  - Latch trig_tag <= pulse_ctr, dly_ctr <= cap_dly, len_reg <= cap_len.
  - Go to DELAY.
  - trig_in while run_s = 0 is ignored and not counted.
- DELAY:
  - Stays exactly cap_dly+1 cycles; dly_ctr decrements to 0, then go to CAPTURE.
  - wr_en first rises in the cycle after the last DELAY cycle. With cap_dly = 0, wr_en is high 2 cycles after the cycle in which trig_in = 1.
- CAPTURE:
  - wr_en = 1 for exactly len_reg cycles (2^ADDR_W cycles when len_reg = 0).
  - wr_addr takes 0,1,…,len−1, one increment per cycle, wrapping modulo 2^ADDR_W.
  - After the last sample: wr_en <= 0, wr_addr <= 0, data_rdy <= 1, go to HOLD.
- HOLD:
  - data_rdy = 1; wait for a rising edge of synchronised readout_done. Edge detect needs 3 clk from the async input.
  - On that edge: data_rdy <= 0, overrun <= 0, go to ARM.
  - A readout_done level already high when HOLD is entered does not count; only a new rising edge does.
- ARM:
  - One cycle, then trig_rdy <= 1 and go to IDLE.
  - This guarantees trig_rdy is low for at least cap_dly + cap_len + 3 cycles, so the divider sees a clean rising edge.
- Missed triggers: trig_in = 1 in any state other than IDLE means:
  - missed_ctr <= missed_ctr + 1, saturating at 255 (no wrap).
  - overrun <= 1.
  - No state change.
- Simultaneous readout_done edge and missed trigger in HOLD: set wins, so overrun ends at 1 and missed_ctr increments.
- missed_ctr clears only on rst.
- run_s falling (any state): on the next edge:
  - wr_en <= 0, wr_addr <= 0, data_rdy <= 0.
  - State <= IDLE, trig_rdy <= 1.
  - trig_tag, missed_ctr and overrun are retained.
- Changes on cap_dly and cap_len have no effect mid-operation; they are used only at the next accepted trigger.
- rst asserted mid-capture forces all reset values immediately, without waiting for a clock.

Test Plan:
1. Basic capture: run = 1, cap_dly = 0, cap_len = 4, pulse_ctr = 6'd17, one trig_in pulse.
   -> trig_rdy low the next cycle; wr_en high 2 cycles after the trigger for 4 cycles with wr_addr 0,1,2,3; then data_rdy = 1 and trig_tag = 17.
2. Delay and full length: cap_dly = 5, cap_len = 0.
   -> first wr_en 7 cycles after trig_in; 1024 writes with wr_addr 0..1023; data_rdy rises the cycle after addr 1023.
3. Readout handshake: in HOLD, raise readout_done asynchronously.
   -> data_rdy falls 3 or 4 cycles later; trig_rdy rises 1 cycle after that; with readout_done held high, no second release occurs.
4. Missed triggers: 3 trig_in pulses during CAPTURE, then 300 pulses during HOLD.
   -> overrun = 1; missed_ctr = 255 (saturated); wr_addr sequence undisturbed; overrun cleared at readout_done edge.
5. Abort: deassert run mid-CAPTURE at wr_addr = 2.
   -> within 3 cycles wr_en = 0, wr_addr = 0, data_rdy = 0, trig_rdy = 1; trig_in while run is low produces no capture and no missed_ctr change.
6. Reset mid-DELAY: pulse rst.
   -> all outputs immediately at reset values; next trigger after rst release runs a normal capture.
